// File: rtl/wms2_video_out_if.sv
// Video port bundle for wms2_video_out: core-side colour/blank/sync inputs
// and scaler-side pixel outputs. The core side drives the master modport.
interface wms2_video_out_if #(
    parameter int unsigned LINE_W = 9
);
    logic [3:0]        r_in;
    logic [3:0]        g_in;
    logic [3:0]        b_in;
    logic [3:0]        i_in;
    logic              hblank_in;
    logic              vblank_in;
    logic              hs_in;
    logic              vs_in;

    logic              ce_pix;
    logic [7:0]        rgb_r;
    logic [7:0]        rgb_g;
    logic [7:0]        rgb_b;
    logic              hblank;
    logic              vblank;
    logic              hsync_n;
    logic              vsync_n;
    logic              de;
    logic [LINE_W-1:0] line_cnt;

    modport master (
        output r_in, g_in, b_in, i_in, hblank_in, vblank_in, hs_in, vs_in,
        input  ce_pix, rgb_r, rgb_g, rgb_b, hblank, vblank, hsync_n, vsync_n, de, line_cnt
    );

    modport slave (
        input  r_in, g_in, b_in, i_in, hblank_in, vblank_in, hs_in, vs_in,
        output ce_pix, rgb_r, rgb_g, rgb_b, hblank, vblank, hsync_n, vsync_n, de, line_cnt
    );
endinterface

// File: rtl/wms2_video_out.sv
// Williams-2 pixel output stage: 1-in-2^DIV_W pixel enable, three-stage
// colour x intensity to 8-bit linear RGB pipeline with aligned blank/sync/DE,
// and a saturating line counter cleared by vsync.
// Optional: define WMS2_BIT_SWAP_EN to reorder R/B nibbles as {c1,c2,c3,c0}.
module wms2_video_out #(
    parameter int unsigned LINE_W = 9,
    parameter int unsigned DIV_W  = 3
) (
    input logic              clk_48,
    input logic              reset_n,
    wms2_video_out_if.slave  vid
);

    logic [DIV_W-1:0]  div_q;
    logic              ce_q;

    logic [3:0]        s1_r_q, s1_g_q, s1_b_q, s1_i_q;
    logic              s1_hb_q, s1_vb_q, s1_hs_q, s1_vs_q;

    logic [7:0]        s2_pr_q, s2_pg_q, s2_pb_q;
    logic              s2_hb_q, s2_vb_q, s2_hs_q, s2_vs_q;

    logic [7:0]        o_r_q, o_g_q, o_b_q;
    logic              o_hb_q, o_vb_q, o_de_q, o_hs_n_q, o_vs_n_q;

    logic              hs_hist_q, vs_hist_q;
    logic [LINE_W-1:0] line_q;

    logic [3:0]        r_cap, b_cap;
    logic              hs_rise, vs_rise, blank2;

`ifdef WMS2_BIT_SWAP_EN
    // Undo the colour-chip wiring on R and B.
    assign r_cap = {vid.r_in[1], vid.r_in[2], vid.r_in[3], vid.r_in[0]};
    assign b_cap = {vid.b_in[1], vid.b_in[2], vid.b_in[3], vid.b_in[0]};
`else
    assign r_cap = vid.r_in;
    assign b_cap = vid.b_in;
`endif

    assign hs_rise = s1_hs_q & ~hs_hist_q;
    assign vs_rise = s1_vs_q & ~vs_hist_q;
    assign blank2  = s2_hb_q | s2_vb_q;

    // 0..225 scaled to 0..255: (p * 1161) >> 10 with an 18-bit product.
    function automatic logic [7:0] scale(input logic [7:0] p);
        logic [17:0] prod;
        prod = {10'd0, p} * 18'd1161;
        return prod[17:10];
    endfunction

    // Free-running divider; ce_pix is registered from the pre-increment value.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= div_q + 1'b1;
            ce_q  <= (div_q == '0);
        end
    end

    // Stage 1: capture core outputs.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            s1_r_q  <= '0;
            s1_g_q  <= '0;
            s1_b_q  <= '0;
            s1_i_q  <= '0;
            s1_hb_q <= 1'b1;
            s1_vb_q <= 1'b1;
            s1_hs_q <= 1'b0;
            s1_vs_q <= 1'b0;
        end else if (ce_q) begin
            s1_r_q  <= r_cap;
            s1_g_q  <= vid.g_in;
            s1_b_q  <= b_cap;
            s1_i_q  <= vid.i_in;
            s1_hb_q <= vid.hblank_in;
            s1_vb_q <= vid.vblank_in;
            s1_hs_q <= vid.hs_in;
            s1_vs_q <= vid.vs_in;
        end
    end

    // Stage 2: colour x intensity products, flags delayed alongside.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            s2_pr_q <= '0;
            s2_pg_q <= '0;
            s2_pb_q <= '0;
            s2_hb_q <= 1'b1;
            s2_vb_q <= 1'b1;
            s2_hs_q <= 1'b0;
            s2_vs_q <= 1'b0;
        end else if (ce_q) begin
            s2_pr_q <= {4'd0, s1_r_q} * {4'd0, s1_i_q};
            s2_pg_q <= {4'd0, s1_g_q} * {4'd0, s1_i_q};
            s2_pb_q <= {4'd0, s1_b_q} * {4'd0, s1_i_q};
            s2_hb_q <= s1_hb_q;
            s2_vb_q <= s1_vb_q;
            s2_hs_q <= s1_hs_q;
            s2_vs_q <= s1_vs_q;
        end
    end

    // Stage 3: scale to 8-bit linear, black during blanking, invert syncs.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            o_r_q    <= '0;
            o_g_q    <= '0;
            o_b_q    <= '0;
            o_hb_q   <= 1'b1;
            o_vb_q   <= 1'b1;
            o_de_q   <= 1'b0;
            o_hs_n_q <= 1'b1;
            o_vs_n_q <= 1'b1;
        end else if (ce_q) begin
            o_r_q    <= blank2 ? 8'd0 : scale(s2_pr_q);
            o_g_q    <= blank2 ? 8'd0 : scale(s2_pg_q);
            o_b_q    <= blank2 ? 8'd0 : scale(s2_pb_q);
            o_hb_q   <= s2_hb_q;
            o_vb_q   <= s2_vb_q;
            o_de_q   <= ~blank2;
            o_hs_n_q <= ~s2_hs_q;
            o_vs_n_q <= ~s2_vs_q;
        end
    end

    // Line counter from stage-1 sync edges; vsync clear wins over hsync count.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            hs_hist_q <= 1'b0;
            vs_hist_q <= 1'b0;
            line_q    <= '0;
        end else if (ce_q) begin
            hs_hist_q <= s1_hs_q;
            vs_hist_q <= s1_vs_q;
            if (vs_rise) begin
                line_q <= '0;
            end else if (hs_rise && (line_q != '1)) begin
                line_q <= line_q + 1'b1;
            end
        end
    end

    assign vid.ce_pix   = ce_q;
    assign vid.rgb_r    = o_r_q;
    assign vid.rgb_g    = o_g_q;
    assign vid.rgb_b    = o_b_q;
    assign vid.hblank   = o_hb_q;
    assign vid.vblank   = o_vb_q;
    assign vid.de       = o_de_q;
    assign vid.hsync_n  = o_hs_n_q;
    assign vid.vsync_n  = o_vs_n_q;
    assign vid.line_cnt = line_q;

endmodule

// File: doc/wms2_video_out.md
# wms2_video_out

Pixel output stage between the Williams-2 core video outputs (4-bit R/G/B plus 4-bit intensity, active-high blank/sync) and the arcade video/scaler input. Generates the 1-in-8 pixel enable from the 48 MHz video clock and converts colour × intensity to 8-bit linear RGB through a three-stage pipeline. Blank, sync and DE travel through the same pipeline so they stay aligned with the colour. A line counter is provided for scaler and debug use.

## Interface
Parameters:
- `LINE_W`, 9, width of the line counter
- `DIV_W`, 3, pixel-enable divider width; one enable every 2^DIV_W clocks

Ports:
- `clk_48`  in  1  video clock, 48 MHz
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `r_in`, `g_in`, `b_in`  in  4 each  core colour nibbles
- `i_in`  in  4  core intensity nibble
- `hblank_in`, `vblank_in`  in  1  active-high blanks from the core
- `hs_in`, `vs_in`  in  1  active-high syncs from the core
- `ce_pix`  out  1  pixel enable, one `clk_48` cycle wide
- `rgb_r`, `rgb_g`, `rgb_b`  out  8 each  linear RGB
- `hblank`, `vblank`  out  1  pipelined blanks
- `hsync_n`, `vsync_n`  out  1  pipelined syncs, inverted
- `de`  out  1  `~(hblank|vblank)`, pipelined
- `line_cnt`  out  LINE_W  count of `hs_in` rising edges since the last `vs_in` rising edge

## Operation
- Divider: `div` increments every clock and wraps at 2^DIV_W. `ce_pix` is registered as `ce_pix <= (div == 0)`, where `div` is the pre-increment value.
- All pipeline registers and the line counter update only on edges where `ce_pix == 1`. They hold otherwise.
- Stage 1 (capture): registers every input.
  - With the bit-swap fix enabled, R is stored as `{r[1],r[2],r[3],r[0]}` and B likewise. G is always stored unchanged.
- Stage 2 (product): `p_c = c × i` for each channel, unsigned 8 bits, range 0..225. Blank and sync flags are delayed alongside.
- Stage 3 (scale/output): `out_c = (p_c × 1161) >> 10`.
  - Intermediate product is 18 bits; result is truncated to 8 bits.
  - Mapping: p=0→0, p=1→1, p=225→255. Result is monotonic.
  - When stage-2 hblank or vblank is set, `out_c` is forced to 0.
  - `de = ~(hblank|vblank)`. `hsync_n = ~hs`, `vsync_n = ~vs`.
- Line counter:
  - Edge detect uses the stage-1 sync values against their previous ce-sampled values.
  - `vs` rising edge clears `line_cnt` to 0. This takes priority over a simultaneous `hs` rise.
  - `hs` rising edge increments `line_cnt`. It saturates at all-ones and does not wrap.
- Zero intensity produces black by construction. No special case is required.

## Timing
- Reset values: `div=0`, `ce_pix=0`, RGB=0, `hblank=1`, `vblank=1`, `de=0`, `hsync_n=1`, `vsync_n=1`, `line_cnt=0`, edge-detect history=0.
- After `reset_n` deasserts, the first `ce_pix` pulse appears on the first clock edge. Pulses then repeat every 8 clocks (DIV_W=3).
- Input to output latency is exactly 3 `ce_pix` pulses. An input sampled at pulse N appears on the outputs after the edge of pulse N+2, and is valid when pulse N+3 is asserted.
- Inputs must be stable at the `ce_pix` sampling edge. Changes between pulses are ignored.
- Reset asserted mid-line returns all outputs to reset values immediately (asynchronous). Pipeline contents are discarded.
- `line_cnt` updates 1 `ce_pix` after the sync edge enters stage 1. Its latency is independent of the colour path.

## Configuration
- `WMS2_BIT_SWAP_EN` defined: R and B nibbles are reordered in stage 1 as described in Operation. This corrects the colour-chip wiring.
- Not defined: R and B pass straight through, like G.
- No other behaviour depends on the macro.

## Test plan
- Reset release, inputs static → `ce_pix` high on cycle 1, 9, 17…. Outputs hold reset values until 3 pulses have passed.
- r=g=b=15, i=15, blanks 0 → after 3 pulses RGB = 255/255/255 and `de=1`. With i=0 → RGB = 0.
- g=1, i=1 → `rgb_g=1`. g=5, i=9 (p=45) → `rgb_g=51`. g=15, i=8 (p=120) → `rgb_g=136`.
- r_in=4'b0010, i=15, with `WMS2_BIT_SWAP_EN` → `rgb_r=136`. Without the macro → `rgb_r=34`.
- hblank_in=1 with full colour → RGB=0 and `de=0`, aligned with the blank (3-pulse latency). hs_in=1 → `hsync_n=0` on the same pulse.
- 5 hs rises then a vs rise coincident with an hs rise → `line_cnt` 5 then 0. 600 hs rises → `line_cnt` saturates at 511. `reset_n` low mid-frame → `line_cnt=0` immediately.
